// File: rtl/reg_file_pkg.sv
// Shared constants for the configuration register bank: named register slots,
// their reset defaults and the legal read-latency check.
package reg_file_pkg;

  localparam int unsigned REG_ALU_OP_A  = 0;
  localparam int unsigned REG_ALU_OP_B  = 1;
  localparam int unsigned REG_UART_CFG  = 2;
  localparam int unsigned REG_DIV_RATIO = 3;

  localparam logic [7:0] DEF_UART_CFG  = 8'h81;
  localparam logic [7:0] DEF_DIV_RATIO = 8'h20;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 16;

  // 16 x 8-bit reset image; every slot not named above resets to zero.
  localparam logic [DEF_DEPTH*DEF_WIDTH-1:0] DEF_INIT_VALS =
      ((DEF_DEPTH*DEF_WIDTH)'(DEF_DIV_RATIO) << (REG_DIV_RATIO * DEF_WIDTH)) |
      ((DEF_DEPTH*DEF_WIDTH)'(DEF_UART_CFG)  << (REG_UART_CFG  * DEF_WIDTH));

  function automatic bit rd_lat_ok(input int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/reg_file_rd_pipe.sv
// Read-response delay line: a valid bit plus payload, Depth stages deep.
// Payload stages only load on valid so the output holds its last response.
module reg_file_rd_pipe #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic [Depth-1:0] valid_q;
  logic [Width-1:0] data_q [Depth];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) begin
        data_q[0] <= data_i;
      end
      for (int unsigned i = 1; i < Depth; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign data_o  = data_q[Depth-1];

endmodule

// File: rtl/reg_file_v2.sv
// Configuration register bank: masked writes, read-first same-cycle access,
// 1- or 2-cycle read latency, read-only protection and per-register change strobes.
module reg_file_v2
  import reg_file_pkg::*;
#(
  parameter int unsigned                WIDTH     = 8,
  parameter int unsigned                DEPTH     = 16,
  parameter int unsigned                ADDR_W    = 4,
  parameter int unsigned                NUM_EXP   = 4,
  parameter int unsigned                RD_LAT    = 1,
  parameter logic [DEPTH-1:0]           RO_MASK   = '0,
  parameter logic [DEPTH*WIDTH-1:0]     INIT_VALS = DEF_INIT_VALS
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WrEn,
  input  logic                     RdEn,
  input  logic [ADDR_W-1:0]        Address,
  input  logic [WIDTH-1:0]         WrData,
  input  logic [WIDTH-1:0]         WrMask,
  output logic [WIDTH-1:0]         RdData,
  output logic                     RdData_Valid,
  output logic                     RdErr,
  output logic                     WrErr,
  output logic [NUM_EXP*WIDTH-1:0] REGS,
  output logic [NUM_EXP-1:0]       Reg_Upd
);

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("reg_file_v2: RD_LAT must be 1 or 2");
  end

  logic [WIDTH-1:0]   regs_q [DEPTH];
  logic [WIDTH-1:0]   regs_d [DEPTH];
  logic [NUM_EXP-1:0] upd_q, upd_d;
  logic               wr_err_q, wr_err_d;

  logic               in_range;
  logic               ro_hit;
  logic               wr_ok;
  logic [WIDTH-1:0]   rd_word;
  logic [WIDTH:0]     pipe_out;

  // A fully populated address space has no out-of-range codes.
  if (DEPTH == (2 ** ADDR_W)) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = (Address < ADDR_W'(DEPTH));
  end

  // Decode by explicit compare so unused address codes never alias a register.
  always_comb begin
    ro_hit  = 1'b0;
    rd_word = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (Address == ADDR_W'(i)) begin
        ro_hit  = RO_MASK[i];
        rd_word = regs_q[i];
      end
    end

    wr_ok    = WrEn && in_range && !ro_hit;
    wr_err_d = WrEn && !wr_ok;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_ok && (Address == ADDR_W'(i))) begin
        regs_d[i] = (regs_q[i] & ~WrMask) | (WrData & WrMask);
      end
    end

    upd_d = '0;
    for (int unsigned i = 0; i < NUM_EXP; i++) begin
      upd_d[i] = (regs_d[i] != regs_q[i]);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= INIT_VALS[i*WIDTH +: WIDTH];
      end
      upd_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      upd_q    <= upd_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Read data is sampled from the pre-write bank, giving read-first ordering.
  reg_file_rd_pipe #(
    .Width (WIDTH + 1),
    .Depth (RD_LAT)
  ) u_rd_pipe (
    .clk_i   (CLK),
    .rst_i   (RST),
    .valid_i (RdEn),
    .data_i  ({!in_range, rd_word}),
    .valid_o (RdData_Valid),
    .data_o  (pipe_out)
  );

  assign RdData  = pipe_out[WIDTH-1:0];
  assign RdErr   = RdData_Valid && pipe_out[WIDTH];
  assign WrErr   = wr_err_q;
  assign Reg_Upd = upd_q;

  for (genvar g = 0; g < NUM_EXP; g++) begin : g_export
    assign REGS[g*WIDTH +: WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_reg_file_v2.sv
// Bench for reg_file_v2: two configurations driven in lockstep and checked
// every cycle against a transaction-level model of the register bank.
module tb_reg_file_v2;
  import reg_file_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] wdata = '0, wmask = '0;

  logic [7:0]  rd_a, rd_b;
  logic        valid_a, valid_b, err_a, err_b, wrerr_a, wrerr_b;
  logic [31:0] regs_a, regs_b;
  logic [3:0]  upd_a, upd_b;

  reg_file_v2 #(
    .WIDTH(8), .DEPTH(16), .ADDR_W(4), .NUM_EXP(4), .RD_LAT(1),
    .RO_MASK(16'h0000), .INIT_VALS(DEF_INIT_VALS)
  ) u_dut_a (
    .CLK(clk), .RST(rst), .WrEn(wr_en), .RdEn(rd_en), .Address(addr),
    .WrData(wdata), .WrMask(wmask), .RdData(rd_a), .RdData_Valid(valid_a),
    .RdErr(err_a), .WrErr(wrerr_a), .REGS(regs_a), .Reg_Upd(upd_a)
  );

  reg_file_v2 #(
    .WIDTH(8), .DEPTH(12), .ADDR_W(4), .NUM_EXP(4), .RD_LAT(2),
    .RO_MASK(12'h008), .INIT_VALS(DEF_INIT_VALS[95:0])
  ) u_dut_b (
    .CLK(clk), .RST(rst), .WrEn(wr_en), .RdEn(rd_en), .Address(addr),
    .WrData(wdata), .WrMask(wmask), .RdData(rd_b), .RdData_Valid(valid_b),
    .RdErr(err_b), .WrErr(wrerr_b), .REGS(regs_b), .Reg_Upd(upd_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: register contents plus a 4-slot timing wheel of pending responses.
  logic [7:0] m_regs [2][16];
  bit         sv [2][4];
  logic [7:0] sd [2][4];
  bit         se [2][4];
  logic [7:0] exp_rd [2];
  bit         exp_v [2], exp_e [2], exp_wrerr [2];
  logic [3:0] exp_upd [2];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int dep_of(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

  function automatic logic [15:0] ro_of(input int d);
    return (d == 0) ? 16'h0000 : 16'h0008;
  endfunction

  function automatic logic [31:0] m_flat(input int d);
    return {m_regs[d][3], m_regs[d][2], m_regs[d][1], m_regs[d][0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset(input int d);
    for (int i = 0; i < 16; i++) m_regs[d][i] = 8'h00;
    m_regs[d][2] = 8'h81;
    m_regs[d][3] = 8'h20;
    for (int s = 0; s < 4; s++) sv[d][s] = 1'b0;
    exp_rd[d] = 8'h00; exp_v[d] = 1'b0; exp_e[d] = 1'b0;
    exp_wrerr[d] = 1'b0; exp_upd[d] = 4'h0;
  endtask

  task automatic model_step(input int d);
    int s;
    logic [7:0] nv;
    logic [15:0] rom;
    bit in_rng;
    if (rst) begin
      model_reset(d);
      return;
    end
    rom = ro_of(d);
    in_rng = (int'(addr) < dep_of(d));
    exp_upd[d] = 4'h0;
    exp_wrerr[d] = 1'b0;
    if (rd_en) begin
      s = (cyc + lat_of(d) - 1) % 4;
      sv[d][s] = 1'b1;
      sd[d][s] = in_rng ? m_regs[d][addr] : 8'h00;
      se[d][s] = !in_rng;
    end
    if (wr_en) begin
      if (in_rng && !rom[addr]) begin
        nv = (m_regs[d][addr] & ~wmask) | (wdata & wmask);
        if (addr < 4 && nv != m_regs[d][addr]) exp_upd[d][addr[1:0]] = 1'b1;
        m_regs[d][addr] = nv;
      end else begin
        exp_wrerr[d] = 1'b1;
      end
    end
    s = cyc % 4;
    if (sv[d][s]) begin
      exp_v[d] = 1'b1; exp_rd[d] = sd[d][s]; exp_e[d] = se[d][s];
      sv[d][s] = 1'b0;
    end else begin
      exp_v[d] = 1'b0; exp_e[d] = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("A.REGS", regs_a, m_flat(0));
    chk("A.Reg_Upd", 32'(upd_a), 32'(exp_upd[0]));
    chk("A.WrErr", 32'(wrerr_a), 32'(exp_wrerr[0]));
    chk("A.RdData_Valid", 32'(valid_a), 32'(exp_v[0]));
    chk("A.RdErr", 32'(err_a), 32'(exp_e[0]));
    chk("A.RdData", 32'(rd_a), 32'(exp_rd[0]));
    chk("B.REGS", regs_b, m_flat(1));
    chk("B.Reg_Upd", 32'(upd_b), 32'(exp_upd[1]));
    chk("B.WrErr", 32'(wrerr_b), 32'(exp_wrerr[1]));
    chk("B.RdData_Valid", 32'(valid_b), 32'(exp_v[1]));
    chk("B.RdErr", 32'(err_b), 32'(exp_e[1]));
    chk("B.RdData", 32'(rd_b), 32'(exp_rd[1]));
  endtask

  // One clock: the model consumes the inputs sampled at the edge, then outputs are compared.
  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  initial begin
    int cnt_a, cnt_b, first_a, first_b;
    model_reset(0);
    model_reset(1);

    cycle();
    cycle();
    rst = 1'b0;
    chk("reset REGS A", regs_a, 32'h2081_0000);
    chk("reset REGS B", regs_b, 32'h2081_0000);

    // Masked write to the UART config slot, then the identical write again.
    wr_en = 1'b1; addr = 4'd2; wdata = 8'hFF; wmask = 8'h0F;
    cycle();
    chk("masked write REGS", regs_a, 32'h208F_0000);
    chk("masked write Reg_Upd", 32'(upd_a), 32'h4);
    cycle();
    chk("repeat write Reg_Upd", 32'(upd_a), 32'h0);
    wr_en = 1'b0;

    // Three back-to-back reads of addr 3.
    cnt_a = 0; cnt_b = 0; first_a = -1; first_b = -1;
    addr = 4'd3;
    for (int k = 0; k < 6; k++) begin
      rd_en = (k < 3);
      cycle();
      if (valid_a) begin
        cnt_a++;
        if (first_a < 0) first_a = k;
        chk("lat1 data", 32'(rd_a), 32'h20);
      end
      if (valid_b) begin
        cnt_b++;
        if (first_b < 0) first_b = k;
        chk("lat2 data", 32'(rd_b), 32'h20);
      end
    end
    chk("lat1 strobes", 32'(cnt_a), 32'd3);
    chk("lat2 strobes", 32'(cnt_b), 32'd3);
    chk("lat1 first", 32'(first_a), 32'd0);
    chk("lat2 first", 32'(first_b), 32'd1);

    // Same-cycle read and write of addr 5 is read-first.
    rd_en = 1'b0; wr_en = 1'b1; addr = 4'd5; wdata = 8'h11; wmask = 8'hFF;
    cycle();
    rd_en = 1'b1; wdata = 8'h22;
    cycle();
    chk("rw A old value", {23'd0, valid_a, rd_a}, {23'd0, 1'b1, 8'h11});
    wr_en = 1'b0;
    cycle();
    chk("rw A new value", 32'(rd_a), 32'h22);
    chk("rw B old value", 32'(rd_b), 32'h11);
    rd_en = 1'b0;
    cycle();
    chk("rw B new value", 32'(rd_b), 32'h22);
    chk("A hold after valid", {23'd0, valid_a, rd_a}, {23'd0, 1'b0, 8'h22});

    // Read-only slot on B, then a write/read of an address B does not implement.
    wr_en = 1'b1; addr = 4'd3; wdata = 8'h00; wmask = 8'hFF;
    cycle();
    chk("RO WrErr B", 32'(wrerr_b), 32'h1);
    chk("RO reg3 B", 32'(regs_b[31:24]), 32'h20);
    chk("RO WrErr A", 32'(wrerr_a), 32'h0);
    addr = 4'd13; wdata = 8'h5A;
    cycle();
    chk("range WrErr B", 32'(wrerr_b), 32'h1);
    wr_en = 1'b0; rd_en = 1'b1;
    cycle();
    chk("range read A", 32'(rd_a), 32'h5A);
    rd_en = 1'b0;
    cycle();
    chk("range read B", {22'd0, valid_b, err_b, rd_b}, {22'd0, 1'b1, 1'b1, 8'h00});

    // Reset while a latency-2 read is in flight.
    rd_en = 1'b1; addr = 4'd3;
    cycle();
    rd_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    compare_all();
    chk("mid-cycle reset REGS A", regs_a, 32'h2081_0000);
    cycle();
    rst = 1'b0;
    cycle();
    chk("no valid after reset B", 32'(valid_b), 32'h0);
    cycle();

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 149) == 0);
      wr_en = $urandom_range(0, 1);
      rd_en = $urandom_range(0, 2) != 0;
      addr  = 4'($urandom_range(0, 15));
      wdata = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       wmask = 8'h00;
        1:       wmask = 8'hFF;
        default: wmask = 8'($urandom);
      endcase
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_v2.md
Name: reg_file_v2

Overview:
Parametrised successor to the system register file. Single-clock configuration register bank with masked writes, same-cycle read and write, programmable read latency, read-only protection, address-range checking and per-register update strobes. Sits between the system controller and the UART/ALU/clock-divider config consumers. Exported registers drive those consumers directly.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 16, number of registers (2..256)
ADDR_W, 4, address width; must satisfy 2**ADDR_W >= DEPTH
NUM_EXP, 4, number of low registers exported on REGS (1..DEPTH)
RD_LAT, 1, read latency in cycles (1 or 2)
RO_MASK, 16'h0000, bit i=1 makes register i read-only (writes rejected)
INIT_VALS, {DEPTH*WIDTH}, packed reset values; register i = INIT_VALS[i*WIDTH +: WIDTH]; default reg2=8'h81, reg3=8'h20, others 0

Ports:
CLK  input  1  system clock; one clock, all logic on rising edge
RST  input  1  reset; asynchronous and active-high
WrEn  input  1  write request, sampled each cycle
RdEn  input  1  read request, sampled each cycle
Address  input  ADDR_W  shared read/write address
WrData  input  WIDTH  write data
WrMask  input  WIDTH  bit-write enable; 1 = update bit
RdData  output  WIDTH  read data
RdData_Valid  output  1  one-cycle strobe qualifying RdData/RdErr
RdErr  output  1  read address out of range (qualified by RdData_Valid)
WrErr  output  1  one-cycle strobe: write rejected (range or RO)
REGS  output  NUM_EXP*WIDTH  registers 0..NUM_EXP-1, flattened, reg0 in LSBs
Reg_Upd  output  NUM_EXP  one-cycle strobe per exported register whose value changed

Behaviour:
- Reset (RST=1, any time, asynchronous): every register <= its INIT_VALS slice; RdData=0, RdData_Valid=0, RdErr=0, WrErr=0, Reg_Upd=0, read pipeline flushed. Reset mid-read: pending read is discarded and no valid is issued.
- Write (WrEn=1): if Address<DEPTH and RO_MASK[Address]=0: reg <= (reg & ~WrMask) | (WrData & WrMask), visible on REGS next cycle. Otherwise register bank unchanged, WrErr=1 the next cycle.
- Reg_Upd[i]=1 the cycle after an accepted write to i<NUM_EXP only if the stored value actually changed. A WrMask of 0 or identical data gives no strobe.
- Read (RdEn=1): RdData/RdData_Valid appear RD_LAT cycles after the request cycle. RdData_Valid is high for exactly one cycle per request. Back-to-back reads every cycle are supported at full throughput for both latencies.
- Out-of-range read: RdData=0, RdErr=1 with RdData_Valid. Reads of RO registers are normal.
- Simultaneous WrEn and RdEn: both performed. On the same address the read returns the pre-write value (read-first). On different addresses the two are independent.
- RdData holds its last value when RdData_Valid=0. RdErr is 0 when RdData_Valid=0.
- RD_LAT=2: address/data captured in stage 1 and registered again in stage 2. A write during stage 2 does not alter in-flight data.
- Address bits beyond DEPTH are never aliased.

Decomposition:
- Package reg_file_pkg: default INIT_VALS constant, named addresses/defaults (REG_ALU_OP_A=0, REG_ALU_OP_B=1, REG_UART_CFG=2 / 8'h81, REG_DIV_RATIO=3 / 8'h20), RD_LAT legal-value check.
- Sub-module reg_file_rd_pipe: parametrised valid/data/err delay line (depth RD_LAT, width WIDTH+1). Instantiated once.

Test Plan:
- Reset: assert RST mid-cycle -> immediately REGS = {8'h20,8'h81,8'h00,8'h00} (reg3..reg0), all outputs 0.
- Masked write: addr 2, WrData=8'hFF, WrMask=8'h0F -> reg2 = 8'h8F, Reg_Upd=4'b0100 next cycle. Repeat the same write -> Reg_Upd=0.
- Read latency: RD_LAT=1 and RD_LAT=2, reads of addr 3 on 3 consecutive cycles -> 3 valid strobes, RdData=8'h20, first valid at cycle +1 or +2.
- Same-cycle RW: reg5=8'h11; WrEn+RdEn addr 5, WrData=8'h22 -> RdData=8'h11 with valid; next read returns 8'h22.
- Protection/range: RO_MASK=16'h0008, write addr 3 -> reg3 unchanged, WrErr=1. DEPTH=12, read addr 13 -> RdData=0, RdErr=1, valid=1.
- Reset mid-read: RD_LAT=2, RdEn then RST the next cycle -> no RdData_Valid issued, registers back to INIT_VALS.
